csr_regfile: RTL and testbench

Control/status register file answering the writeback stage's CSR and exception interface; it is the responder end of that interface.
- Serves combinational CSR reads and masked CSR writes.
- Records exception and ertn state, and supplies the exception and return entry PCs.
- Aggregates interrupt lines and runs the constant timer.
- Sits beside the WB stage; entry PCs feed the IF-stage redirect.

---
 rtl/csr_regfile.sv | 237 +++++++++++++++++++++++
 tb/tb_csr_regfile.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Purpose: CSR file beside WB. It serves reads and masked writes, records exception and ertn state, aggregates interrupts and runs the constant timer.
// Latency: reads, has_int, ex_entry and ertn_entry are combinational. All state updates land on the rising clk edge.
// Backpressure: none. Every request is accepted in its own cycle. A write is dropped in a cycle that carries wb_ex.
module csr_regfile #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic        ertn_flush,
    input  logic [31:0] wb_pc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_vaddr,
    input  logic        ipi_int_in,
    input  logic [7:0]  hw_int_in,
    input  logic [31:0] coreid_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry
);

    localparam logic [13:0] A_CRMD   = 14'h00;
    localparam logic [13:0] A_PRMD   = 14'h01;
    localparam logic [13:0] A_ECFG   = 14'h04;
    localparam logic [13:0] A_ESTAT  = 14'h05;
    localparam logic [13:0] A_ERA    = 14'h06;
    localparam logic [13:0] A_BADV   = 14'h07;
    localparam logic [13:0] A_EENTRY = 14'h0C;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;
    localparam logic [13:0] A_TICLR  = 14'h44;
    localparam logic [5:0]  EC_ADEF  = 6'h08;
    localparam logic [5:0]  EC_ALE   = 6'h09;

    // CRMD holds PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5] and DATM[8:7]. PRMD holds PPLV[1:0] and PIE[2].
    logic [8:0]         crmd;
    logic [2:0]         prmd;
    logic [12:0]        ecfg_lie;
    logic [12:0]        estat_is;
    logic [5:0]         estat_ecode;
    logic [8:0]         estat_esubcode;
    logic [31:0]        era;
    logic [31:0]        badv;
    logic [25:0]        eentry;
    logic [31:0]        save_r [0:3];
    logic [31:0]        tid;
    logic [TIMER_W-1:0] tcfg;
    logic [TIMER_W-1:0] tval;

    // The read path does not depend on csr_re, so that input is left unused here.
    logic unused_csr_re;
    assign unused_csr_re = csr_re;

    // An exception commit drops any CSR write in the same cycle.
    logic        wr_en;
    logic [31:0] wsel;
    logic [31:0] wkeep;
    assign wr_en = csr_we & ~wb_ex;
    assign wsel  = csr_wvalue & csr_wmask;
    assign wkeep = ~csr_wmask;

    logic [8:0]         crmd_m;
    logic [2:0]         prmd_m;
    logic [12:0]        ecfg_m;
    logic [1:0]         swi_m;
    logic [31:0]        era_m;
    logic [31:0]        badv_m;
    logic [25:0]        eentry_m;
    logic [31:0]        save_m;
    logic [31:0]        tid_m;
    logic [TIMER_W-1:0] tcfg_m;
    assign crmd_m   = (crmd & wkeep[8:0]) | wsel[8:0];
    assign prmd_m   = (prmd & wkeep[2:0]) | wsel[2:0];
    assign ecfg_m   = ((ecfg_lie & wkeep[12:0]) | wsel[12:0]) & 13'h1BFF;
    assign swi_m    = (estat_is[1:0] & wkeep[1:0]) | wsel[1:0];
    assign era_m    = (era & wkeep) | wsel;
    assign badv_m   = (badv & wkeep) | wsel;
    assign eentry_m = (eentry & wkeep[31:6]) | wsel[31:6];
    assign save_m   = (save_r[csr_num[1:0]] & wkeep) | wsel;
    assign tid_m    = (tid & wkeep) | wsel;
    assign tcfg_m   = (tcfg & wkeep[TIMER_W-1:0]) | wsel[TIMER_W-1:0];

    logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry, wr_save, wr_tid, wr_tcfg;
    assign wr_crmd   = wr_en && (csr_num == A_CRMD);
    assign wr_prmd   = wr_en && (csr_num == A_PRMD);
    assign wr_ecfg   = wr_en && (csr_num == A_ECFG);
    assign wr_estat  = wr_en && (csr_num == A_ESTAT);
    assign wr_era    = wr_en && (csr_num == A_ERA);
    assign wr_badv   = wr_en && (csr_num == A_BADV);
    assign wr_eentry = wr_en && (csr_num == A_EENTRY);
    assign wr_save   = wr_en && (csr_num[13:2] == 12'h00C);
    assign wr_tid    = wr_en && (csr_num == A_TID);
    assign wr_tcfg   = wr_en && (csr_num == A_TCFG);

    // The timer fires while enabled at zero. A concurrent TICLR clear loses to a fire.
    logic               timer_fire;
    logic               ticlr_clr;
    logic [TIMER_W-1:0] tval_reload;
    logic [TIMER_W-1:0] tval_load;
    assign timer_fire  = tcfg[0] && (tval == '0);
    assign ticlr_clr   = wr_en && (csr_num == A_TICLR) && wsel[0];
    assign tval_reload = {tcfg[TIMER_W-1:2], 2'b00};
    assign tval_load   = {tcfg_m[TIMER_W-1:2], 2'b00};

    // Mode state. Exception beats ertn, and ertn beats a write on PLV/IE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd <= 9'h008;
            prmd <= 3'b000;
        end else if (wb_ex) begin
            crmd[2:0] <= 3'b000;
            prmd      <= crmd[2:0];
        end else begin
            if (ertn_flush)
                crmd[2:0] <= prmd;
            else if (wr_crmd)
                crmd[2:0] <= crmd_m[2:0];
            if (wr_crmd)
                crmd[8:3] <= crmd_m[8:3];
            if (wr_prmd)
                prmd <= prmd_m;
        end
    end

    // Exception status: the interrupt lines are sampled every cycle and the timer bit is sticky.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            estat_is       <= '0;
            estat_ecode    <= '0;
            estat_esubcode <= '0;
        end else begin
            estat_is[9:2] <= hw_int_in;
            estat_is[10]  <= 1'b0;
            estat_is[12]  <= ipi_int_in;
            if (timer_fire)
                estat_is[11] <= 1'b1;
            else if (ticlr_clr)
                estat_is[11] <= 1'b0;
            if (wr_estat)
                estat_is[1:0] <= swi_m;
            if (wb_ex) begin
                estat_ecode    <= wb_ecode;
                estat_esubcode <= wb_esubcode;
            end
        end
    end

    // Return PC and bad address are captured on an exception. Otherwise they are software writable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            era  <= '0;
            badv <= '0;
        end else begin
            if (wb_ex)
                era <= wb_pc;
            else if (wr_era)
                era <= era_m;
            if (wb_ex && wb_ecode == EC_ADEF)
                badv <= wb_pc;
            else if (wb_ex && wb_ecode == EC_ALE)
                badv <= wb_vaddr;
            else if (wr_badv)
                badv <= badv_m;
        end
    end

    // These registers change only through software writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ecfg_lie <= '0;
            eentry   <= '0;
            tid      <= coreid_in;
            for (int i = 0; i < 4; i++)
                save_r[i] <= '0;
        end else begin
            if (wr_ecfg)
                ecfg_lie <= ecfg_m;
            if (wr_eentry)
                eentry <= eentry_m;
            if (wr_tid)
                tid <= tid_m;
            if (wr_save)
                save_r[csr_num[1:0]] <= save_m;
        end
    end

    // Constant timer. Enabling it through a TCFG write loads TVAL on that same edge. All-ones means the timer is stopped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg <= '0;
            tval <= '1;
        end else begin
            if (wr_tcfg)
                tcfg <= tcfg_m;
            if (wr_tcfg && tcfg_m[0])
                tval <= tval_load;
            else if (tcfg[0]) begin
                if (tval == '0)
                    tval <= tcfg[1] ? tval_reload : '1;
                else if (tval != '1)
                    tval <= tval - {{(TIMER_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Combinational read mux. Reserved bits, TICLR and unknown addresses read as zero.
    always_comb begin
        csr_rvalue = '0;
        case (csr_num)
            A_CRMD:   csr_rvalue[8:0]  = crmd;
            A_PRMD:   csr_rvalue[2:0]  = prmd;
            A_ECFG:   csr_rvalue[12:0] = ecfg_lie;
            A_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b000, estat_is};
            A_ERA:    csr_rvalue = era;
            A_BADV:   csr_rvalue = badv;
            A_EENTRY: csr_rvalue = {eentry, 6'b000000};
            14'h30, 14'h31, 14'h32, 14'h33: csr_rvalue = save_r[csr_num[1:0]];
            A_TID:    csr_rvalue = tid;
            A_TCFG:   csr_rvalue[TIMER_W-1:0] = tcfg;
            A_TVAL:   csr_rvalue[TIMER_W-1:0] = tval;
            default:  csr_rvalue = '0;
        endcase
    end

    assign has_int    = crmd[2] & (|(estat_is & ecfg_lie));
    assign ex_entry   = {eentry, 6'b000000};
    assign ertn_entry = era;

endmodule

// File: tb/tb_csr_regfile.sv
// Purpose: directed self-checking bench for csr_regfile, with hand-computed expected values.
// Latency: inputs are driven 1 ns after a rising edge. Results are read back after the next edge.
// Backpressure: none; the DUT accepts every request in its own cycle.
module tb_csr_regfile;

    logic        clk;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic        ipi_int_in;
    logic [7:0]  hw_int_in;
    logic [31:0] coreid_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    int n_checks = 0;
    int n_fail   = 0;

    csr_regfile #(.TIMER_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .csr_re      (csr_re),
        .csr_num     (csr_num),
        .csr_rvalue  (csr_rvalue),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .wb_ex       (wb_ex),
        .ertn_flush  (ertn_flush),
        .wb_pc       (wb_pc),
        .wb_ecode    (wb_ecode),
        .wb_esubcode (wb_esubcode),
        .wb_vaddr    (wb_vaddr),
        .ipi_int_in  (ipi_int_in),
        .hw_int_in   (hw_int_in),
        .coreid_in   (coreid_in),
        .has_int     (has_int),
        .ex_entry    (ex_entry),
        .ertn_entry  (ertn_entry)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_csr(input string tag, input logic [13:0] num, input logic [31:0] exp);
        csr_num = num;
        #1;
        check_eq(tag, csr_rvalue, exp);
    endtask

    task automatic csr_wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_num    = num;
        csr_wmask  = mask;
        csr_wvalue = val;
        csr_we     = 1'b1;
        tick();
        csr_we     = 1'b0;
        csr_wmask  = '0;
    endtask

    initial begin
        logic found;
        resetn      = 1'b0;
        csr_re      = 1'b1;
        csr_num     = '0;
        csr_we      = 1'b0;
        csr_wmask   = '0;
        csr_wvalue  = '0;
        wb_ex       = 1'b0;
        ertn_flush  = 1'b0;
        wb_pc       = '0;
        wb_ecode    = '0;
        wb_esubcode = '0;
        wb_vaddr    = '0;
        ipi_int_in  = 1'b0;
        hw_int_in   = '0;
        coreid_in   = 32'h0000_0003;
        #25 resetn  = 1'b1;
        tick();

        // Reset values
        check_csr("rst_crmd",  14'h00, 32'h0000_0008);
        check_csr("rst_estat", 14'h05, 32'h0000_0000);
        check_csr("rst_tid",   14'h40, 32'h0000_0003);
        check_csr("rst_unimp", 14'h99, 32'h0000_0000);
        check_csr("rst_tval",  14'h42, 32'hFFFF_FFFF);

        // Masked writes and writable-field restriction
        csr_wr(14'h00, 32'h0000_0003, 32'h0000_0007);
        check_csr("crmd_masked", 14'h00, 32'h0000_000B);
        csr_wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_csr("estat_swi_only", 14'h05, 32'h0000_0003);

        // A read in the same cycle as a write sees the old value
        csr_num    = 14'h31;
        csr_wmask  = 32'hFFFF_FFFF;
        csr_wvalue = 32'h1234_5678;
        csr_we     = 1'b1;
        #1;
        check_eq("save1_old_on_write", csr_rvalue, 32'h0000_0000);
        tick();
        csr_we = 1'b0;
        check_csr("save1_new", 14'h31, 32'h1234_5678);

        // Exception: ALE, then ertn
        csr_wr(14'h00, 32'h0000_0007, 32'h0000_0007);
        wb_ex    = 1'b1;
        wb_ecode = 6'h09;
        wb_pc    = 32'h1C00_0100;
        wb_vaddr = 32'h0000_1001;
        tick();
        wb_ex = 1'b0;
        check_csr("ex_crmd",  14'h00, 32'h0000_0008);
        check_csr("ex_prmd",  14'h01, 32'h0000_0007);
        check_csr("ex_era",   14'h06, 32'h1C00_0100);
        check_csr("ex_badv",  14'h07, 32'h0000_1001);
        check_csr("ex_estat", 14'h05, 32'h0009_0003);
        check_eq("ertn_entry", ertn_entry, 32'h1C00_0100);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        check_csr("ertn_crmd", 14'h00, 32'h0000_000F);

        // Timer: InitVal=3, periodic, enabled
        csr_wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0800);
        check_csr("ecfg", 14'h04, 32'h0000_0800);
        csr_wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000F);
        check_csr("tval_load", 14'h42, 32'd12);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_csr("tval_count", 14'h42, 32'd12 - i);
        end
        check_csr("estat_before_fire", 14'h05, 32'h0009_0003);
        check_eq("has_int_before_fire", {31'd0, has_int}, 32'd0);
        tick();
        check_csr("estat_fire", 14'h05, 32'h0009_0803);
        check_csr("tval_reload", 14'h42, 32'd12);
        check_eq("has_int_fire", {31'd0, has_int}, 32'd1);
        csr_wr(14'h44, 32'hFFFF_FFFF, 32'h0000_0001);
        check_csr("ticlr_clear", 14'h05, 32'h0009_0003);
        check_eq("has_int_cleared", {31'd0, has_int}, 32'd0);
        check_csr("tval_after_ticlr", 14'h42, 32'd11);

        // TICLR in the timer-zero cycle: the set wins
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            csr_num = 14'h42;
            #1;
            if (csr_rvalue == 32'd0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("tval_reach_zero", {31'd0, found}, 32'd1);
        csr_wr(14'h44, 32'hFFFF_FFFF, 32'h0000_0001);
        check_csr("set_beats_clear", 14'h05, 32'h0009_0803);
        check_csr("tval_reload2", 14'h42, 32'd12);

        // An exception in the same cycle as an ERA write: the exception wins and BADV is kept
        wb_ex      = 1'b1;
        wb_ecode   = 6'h00;
        wb_pc      = 32'h1C00_0200;
        csr_num    = 14'h06;
        csr_wmask  = 32'hFFFF_FFFF;
        csr_wvalue = 32'hDEAD_BEEF;
        csr_we     = 1'b1;
        tick();
        wb_ex  = 1'b0;
        csr_we = 1'b0;
        check_csr("ex_over_write_era", 14'h06, 32'h1C00_0200);
        check_csr("badv_kept", 14'h07, 32'h0000_1001);
        check_eq("ertn_entry2", ertn_entry, 32'h1C00_0200);

        // ADEF captures the PC into BADV
        wb_ex    = 1'b1;
        wb_ecode = 6'h08;
        wb_pc    = 32'h1C00_0300;
        wb_vaddr = 32'h0000_0055;
        tick();
        wb_ex = 1'b0;
        check_csr("adef_badv", 14'h07, 32'h1C00_0300);

        // EENTRY has its low bits reserved
        csr_wr(14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_csr("eentry", 14'h0C, 32'hFFFF_FFC0);
        check_eq("ex_entry", ex_entry, 32'hFFFF_FFC0);

        // Hardware and IPI lines are sampled into ESTAT.IS
        hw_int_in  = 8'h81;
        ipi_int_in = 1'b1;
        tick();
        csr_num = 14'h05;
        #1;
        check_eq("estat_hw_ipi", csr_rvalue & 32'h0000_17FC, 32'h0000_1204);
        hw_int_in  = 8'h00;
        ipi_int_in = 1'b0;

        // Asynchronous reset while the timer is counting
        #3;
        resetn = 1'b0;
        check_csr("arst_tval", 14'h42, 32'hFFFF_FFFF);
        check_csr("arst_tcfg", 14'h41, 32'h0000_0000);
        check_csr("arst_crmd", 14'h00, 32'h0000_0008);
        check_csr("arst_tid",  14'h40, 32'h0000_0003);
        #20 resetn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
